// File: rtl/uart_rx_os.sv
// ---------------------------------------------------------------------------
// uart_rx_os -- UART receiver with 16x oversampling and an output FIFO
//
// The asynchronous rxd pin goes through a two-flop synchroniser. A runtime
// divisor produces oversample ticks. Each bit is resolved by a 3-sample
// majority vote taken at sample indices 7, 8 and 9. Completed words
// {perr, ferr, data} are pushed into a small FIFO that the consumer drains
// through a valid/ready handshake. An all-zero frame (data, parity and every
// stop bit low) is reported as a break and is never pushed.
//
// Ports
//   clk        clock
//   rst        asynchronous, active-high reset
//   baud_div   oversample tick period minus 1 (bit = 16*(baud_div+1) clk),
//              captured at each start edge
//   rxd        asynchronous serial input, idle high
//   m_data     data of the FIFO head word (0 while the FIFO is empty)
//   m_perr     parity error flag of the head word (always 0 without parity)
//   m_ferr     framing error flag of the head word
//   m_valid    FIFO not empty
//   m_ready    consumer accepts the head word this cycle
//   overrun    one-cycle pulse: a completed word was dropped, FIFO full
//   break_det  one-cycle pulse: a break frame was seen
//   busy       a frame is being received (state is not IDLE)
// ---------------------------------------------------------------------------
module uart_rx_os #(
  parameter int DATA_BITS  = 8,   // 5..9, LSB first
  parameter int PARITY     = 0,   // 0 none, 1 even, 2 odd
  parameter int STOP_BITS  = 1,   // 1 or 2
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4    // power of 2, >= 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_perr,
  output logic                 m_ferr,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int AW     = PTR_W - 1;
  localparam int WORD_W = DATA_BITS + 2;

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [3:0] IDX_S7    = 4'd7;
  localparam logic [3:0] IDX_S8    = 4'd8;
  localparam logic [3:0] IDX_VOTE  = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRK_WAIT
  } state_t;

  // Synchroniser and edge detect
  logic rx_meta_q, rx_meta_d;
  logic rxs_q, rxs_d;
  logic rxs_prev_q, rxs_prev_d;

  // Frame engine
  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [DIV_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [3:0]           samp_idx_q, samp_idx_d;
  logic                 s7_q, s7_d;
  logic                 s8_q, s8_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;      // every voted bit so far was 0

  // Completion stage, registered so the FIFO write lands one cycle later
  logic                 push_q, push_d;
  logic [WORD_W-1:0]    push_word_q, push_word_d;
  logic                 brk_pulse_q, brk_pulse_d;
  logic                 overrun_q, overrun_d;

  // FIFO
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [WORD_W-1:0]    fifo_mem [FIFO_DEPTH];

  // Combinational helpers
  logic              counting;
  logic              tick;
  logic              at_vote;
  logic              vote;
  logic              exp_par;
  logic              stop_ferr;
  logic              stop_brk;
  logic              start_edge;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              do_push;
  logic [WORD_W-1:0] head;

  // -------------------------------------------------------------------------
  // Tick, vote and framing helpers
  // -------------------------------------------------------------------------
  assign counting   = (state_q != S_IDLE) && (state_q != S_BRK_WAIT);
  assign tick       = counting && (tick_cnt_q == div_q);
  assign at_vote    = tick && (samp_idx_q == IDX_VOTE);
  assign vote       = (s7_q & s8_q) | (s7_q & rxs_q) | (s8_q & rxs_q);
  assign exp_par    = (PARITY == 2) ? ~(^shift_q) : (^shift_q);
  assign stop_ferr  = ferr_q | ~vote;
  assign stop_brk   = brk_q & ~vote;
  assign start_edge = rxs_prev_q & ~rxs_q;

  // -------------------------------------------------------------------------
  // FIFO control; pointers carry one extra wrap bit to tell full from empty
  // -------------------------------------------------------------------------
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = !fifo_empty && m_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push    = push_q && (!fifo_full || pop);
  assign head       = fifo_mem[rd_ptr_q[AW-1:0]];

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d gets a default before any branch, so no path through
    // this block can leave a signal unassigned and infer a latch.
    rx_meta_d   = rxd;
    rxs_d       = rx_meta_q;
    rxs_prev_d  = rxs_q;
    state_d     = state_q;
    div_d       = div_q;
    tick_cnt_d  = tick_cnt_q;
    samp_idx_d  = samp_idx_q;
    s7_d        = s7_q;
    s8_d        = s8_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    brk_d       = brk_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    brk_pulse_d = 1'b0;
    overrun_d   = push_q && fifo_full && !pop;
    wr_ptr_d    = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);

    // Tick counter runs 0..div_q only while a frame is in progress.
    if (!counting || tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + DIV_W'(1);
    end

    if (tick) begin
      samp_idx_d = samp_idx_q + 4'd1;
      if (samp_idx_q == IDX_S7) s7_d = rxs_q;
      if (samp_idx_q == IDX_S8) s8_d = rxs_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d    = S_START;
          div_d      = baud_div;
          samp_idx_d = '0;
          bit_cnt_d  = '0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          brk_d      = 1'b1;
        end
      end

      S_START: begin
        // A start bit that votes high was noise; drop back silently.
        if (at_vote) begin
          state_d = vote ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        if (at_vote) begin
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
          brk_d   = brk_q & ~vote;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end

      S_PARITY: begin
        if (at_vote) begin
          perr_d  = (vote != exp_par);
          brk_d   = brk_q & ~vote;
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (at_vote) begin
          ferr_d = stop_ferr;
          brk_d  = stop_brk;
          if (bit_cnt_q == LAST_STOP) begin
            // The frame ends mid-stop-bit so a back-to-back start edge
            // is still seen from IDLE.
            bit_cnt_d = '0;
            if (stop_brk) begin
              brk_pulse_d = 1'b1;
              state_d     = S_BRK_WAIT;
            end else begin
              push_d      = 1'b1;
              push_word_d = {perr_q, stop_ferr, shift_q};
              state_d     = S_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end

      S_BRK_WAIT: begin
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments here, so every flop samples the value
    // its _d had before this edge regardless of statement order.
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_prev_q  <= 1'b1;
      state_q     <= S_IDLE;
      div_q       <= '0;
      tick_cnt_q  <= '0;
      samp_idx_q  <= '0;
      s7_q        <= 1'b0;
      s8_q        <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      brk_q       <= 1'b0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      brk_pulse_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rxs_q       <= rxs_d;
      rxs_prev_q  <= rxs_prev_d;
      state_q     <= state_d;
      div_q       <= div_d;
      tick_cnt_q  <= tick_cnt_d;
      samp_idx_q  <= samp_idx_d;
      s7_q        <= s7_d;
      s8_q        <= s8_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      brk_q       <= brk_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
      brk_pulse_q <= brk_pulse_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // NOTE: the storage array has no reset; emptiness comes from the pointers
  // and the outputs are gated with m_valid, so stale entries never show.
  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= push_word_q;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign m_valid   = !fifo_empty;
  assign m_data    = m_valid ? head[DATA_BITS-1:0] : '0;
  assign m_ferr    = m_valid & head[DATA_BITS];
  assign m_perr    = m_valid & head[DATA_BITS+1];
  assign overrun   = overrun_q;
  assign break_det = brk_pulse_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised UART receiver with 16x oversampling, 3-sample majority vote, runtime baud divisor, configurable data/parity/stop format, break detection and an output FIFO with valid/ready handshake. It replaces the fixed-rate single-sample receiver. It sits between the asynchronous rxd pin and any byte-stream consumer, such as a command parser or bus bridge.

Parameters:
DATA_BITS, 8, data bits per frame, 5..9, LSB first
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits, 1 or 2
DIV_W, 16, width of baud_div
FIFO_DEPTH, 4, output FIFO entries; power of 2, at least 2

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
baud_div  in  DIV_W  oversample tick period minus 1; bit period = 16*(baud_div+1) clk
rxd  in  1  asynchronous serial input, idle high
m_data  out  DATA_BITS  received word at FIFO head
m_perr  out  1  parity error flag of head word; always 0 when PARITY=0
m_ferr  out  1  framing error flag of head word
m_valid  out  1  FIFO not empty
m_ready  in  1  consumer accepts head word
overrun  out  1  one-cycle pulse: completed word dropped because FIFO full
break_det  out  1  one-cycle pulse: break frame detected
busy  out  1  frame reception in progress (state is not IDLE)

Behaviour:
- Reset values: m_valid=0, m_data=0, m_perr=0, m_ferr=0, overrun=0, break_det=0, busy=0. FIFO empty, state IDLE, synchroniser flops=1, all counters 0.
- rxd passes through a 2-flop synchroniser. All logic uses the synchronised value rxs.
- Tick generator:
  - Counter is held at 0 in IDLE and BRK_WAIT.
  - Otherwise it counts 0..div_q and emits a tick when the count equals div_q, then wraps to 0.
  - div_q latches baud_div on start detection. Changes to baud_div mid-frame have no effect.
- Sample index: 4-bit counter, incremented per tick, wraps 15 to 0. Bit value = majority of rxs captured at indices 7, 8 and 9; evaluated at index 9.
- State machine:
  - IDLE: a 1 to 0 transition on rxs enters START. div_q is latched, tick and sample counters clear.
  - START: at index 9, majority 1 means false start; return to IDLE with no output. Majority 0 enters DATA.
  - DATA: one bit per 16 ticks, shifted in LSB first. After DATA_BITS bits, go to PARITY if PARITY≠0, else to STOP.
  - PARITY: compare voted bit with the expected bit. Even: expected = XOR of data. Odd: expected = inverted XOR of data. Mismatch sets perr.
  - STOP: sample STOP_BITS bits. Any voted 0 sets ferr.
  - At index 9 of the last stop bit, go to IDLE and perform completion (below). The frame ends mid-stop-bit, so a back-to-back start edge is caught.
  - BRK_WAIT: stay until rxs=1, then go to IDLE.
- Completion:
  - Break: data=0, parity bit 0 (if present) and every stop bit 0. Pulse break_det, push nothing, enter BRK_WAIT instead of IDLE.
  - Otherwise push {perr, ferr, data} into the FIFO.
  - If the FIFO is full and not popped in the same cycle, drop the word and pulse overrun.
- FIFO:
  - Pop when m_valid and m_ready.
  - Push and pop in the same cycle while full: both happen, no overrun.
  - m_valid rises the cycle after the push edge. Latency from last-stop-bit index-9 tick to m_valid: 2 clk.
  - Output fields hold the head entry. m_data, m_perr and m_ferr are stable while m_valid=1 and m_ready=0.
  - Read/write pointers are log2(FIFO_DEPTH)+1 bits wide, wrapping naturally.
- rst mid-frame: the partial frame is discarded and no flag pulses. FIFO contents are lost.

Test Plan:
1. Defaults, baud_div=3 (64 clk/bit), send 0x55 8N1 → one m_valid with m_data=0x55, m_perr=0, m_ferr=0. m_ready=1 pops it; m_valid=0 the next cycle.
2. rxd low for 20 clk, then high → no m_valid. busy returns to 0 after the START check. A single-clock low glitch at sample index 8 of a data bit in frame 0xF0 still yields 0xF0.
3. Send 0x3C with the stop bit driven 0 → m_data=0x3C, m_ferr=1, break_det=0.
4. PARITY=1 instance, send 0x07 with parity bit 0 → m_perr=1. Resend with parity bit 1 → m_perr=0. PARITY=2 with 0x07 and parity bit 0 → m_perr=0.
5. m_ready=0, send 5 frames 0x01..0x05 back-to-back → overrun pulses once, on frame 5. With m_ready then high, the FIFO drains 0x01..0x04 in order and m_valid drops after 4 pops.
6. rxd held low for 2 frame times → exactly one break_det pulse, no push, busy stays 1. rxd goes high, then frame 0x81 is sent → m_data=0x81 with no error flags. Also: assert rst mid-frame → all outputs return to reset values and the next frame is received correctly.
